// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the two-requester FPU arbiter.
package fpu_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/fpu_arbiter_fpu_unit.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
// Denormal inputs and results flush to signed zero; results with exponent >= 255 become infinity.
module FPU_unit #(
    parameter int NUM_OP = 1
) (
    input  logic        i_add_sub,
    input  logic [31:0] i_32_a,
    input  logic [31:0] i_32_b,
    output logic [31:0] o_32_s,
    output logic        o_ov_flag,
    output logic        o_un_flag
);

    logic              sub_en, sa, sb, swap, big_s;
    logic [7:0]        ea, eb, big_e, small_e, diff;
    logic [22:0]       fa, fb, big_f, small_f;
    logic [23:0]       big_m, small_m, f24;
    logic [4:0]        sh, pos, lz;
    logic [49:0]       small_ext;
    logic [26:0]       big_al, small_al, n;
    logic [27:0]       r;
    logic signed [9:0] e_work;
    logic              a_spec, b_spec, a_nan, b_nan, up;

    always_comb begin
        // NUM_OP = 0 builds an add-only unit
        sub_en  = (NUM_OP >= 1) && i_add_sub;
        ea      = i_32_a[30:23];
        eb      = i_32_b[30:23];
        fa      = i_32_a[22:0];
        fb      = i_32_b[22:0];
        sa      = i_32_a[31];
        sb      = i_32_b[31] ^ sub_en;
        a_spec  = &ea;
        b_spec  = &eb;
        a_nan   = a_spec && (|fa);
        b_nan   = b_spec && (|fb);

        swap    = {eb, fb} > {ea, fa};
        big_s   = swap ? sb : sa;
        big_e   = swap ? eb : ea;
        big_f   = swap ? fb : fa;
        small_e = swap ? ea : eb;
        small_f = swap ? fa : fb;
        big_m   = (big_e == 8'd0) ? 24'd0 : {1'b1, big_f};
        small_m = (small_e == 8'd0) ? 24'd0 : {1'b1, small_f};

        // Alignment keeps guard/round bits; everything shifted further folds into sticky
        diff      = big_e - small_e;
        sh        = (diff > 8'd26) ? 5'd26 : diff[4:0];
        small_ext = {small_m, 26'd0} >> sh;
        small_al  = {small_ext[49:24], |small_ext[23:0]};
        big_al    = {big_m, 3'b000};
        r = (sa == sb) ? ({1'b0, big_al} + {1'b0, small_al})
                       : ({1'b0, big_al} - {1'b0, small_al});

        pos = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (r[i]) pos = 5'(i);
        end
        lz = 5'd26 - pos;

        if (r[27]) begin
            n      = {r[27:2], r[1] | r[0]};
            e_work = $signed({2'b00, big_e}) + 10'sd1;
        end else begin
            n      = r[26:0] << lz;
            e_work = $signed({2'b00, big_e}) - $signed({5'd0, lz});
        end

        up  = n[2] & (n[1] | n[0] | n[3]);
        f24 = {1'b0, n[25:3]} + {23'd0, up};
        if (f24[23]) e_work = e_work + 10'sd1;

        o_ov_flag = 1'b0;
        o_un_flag = 1'b0;
        if (a_spec || b_spec) begin
            if (a_nan || b_nan || (a_spec && b_spec && (sa != sb)))
                o_32_s = 32'h7FC0_0000;
            else
                o_32_s = {(a_spec ? sa : sb), 8'hFF, 23'd0};
        end else if (!n[26]) begin
            o_32_s = 32'd0;
        end else if (e_work >= 10'sd255) begin
            o_ov_flag = 1'b1;
            o_32_s    = {big_s, 8'hFF, 23'd0};
        end else if (e_work <= 10'sd0) begin
            o_un_flag = 1'b1;
            o_32_s    = {big_s, 31'd0};
        end else begin
            o_32_s    = {big_s, e_work[7:0], f24[22:0]};
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one combinational FPU_unit between two requesters.
// One operation in flight: IDLE (grant/capture) -> EXEC (compute/latch) -> RESP (hold until accepted).
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_OP  = 1,
    parameter int NUM_REQ = fpu_arb_pkg::NUM_REQ
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ-1:0]       i_add_sub,
    input  logic [NUM_REQ-1:0][31:0] i_32_a,
    input  logic [NUM_REQ-1:0][31:0] i_32_b,
    output logic [NUM_REQ-1:0]       o_rsp_valid,
    input  logic [NUM_REQ-1:0]       i_rsp_ready,
    output logic [31:0]              o_32_s,
    output logic                     o_ov_flag,
    output logic                     o_un_flag,
    output logic                     o_rsp_id,
    output logic                     o_busy
);

    state_t      state_reg;
    logic        rr_reg;
    logic        owner_reg;
    logic        op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        any_valid;
    logic        grant_idx;
    logic [31:0] fpu_s;
    logic        fpu_ov;
    logic        fpu_un;

    assign any_valid = |i_req_valid;
    // Contention goes to the round-robin pointer; otherwise the lone valid requester wins
    assign grant_idx = (&i_req_valid) ? rr_reg : i_req_valid[1];
    assign o_busy    = !i_rst && (state_reg != IDLE);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign o_req_ready[gi] = !i_rst && (state_reg == IDLE) && any_valid
                                     && (grant_idx == 1'(gi));
            assign o_rsp_valid[gi] = !i_rst && (state_reg == RESP) && (o_rsp_id == 1'(gi));
        end
    endgenerate

    FPU_unit #(
        .NUM_OP(NUM_OP)
    ) u_fpu (
        .i_add_sub(op_reg),
        .i_32_a   (a_reg),
        .i_32_b   (b_reg),
        .o_32_s   (fpu_s),
        .o_ov_flag(fpu_ov),
        .o_un_flag(fpu_un)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            owner_reg <= 1'b0;
            op_reg    <= 1'b0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            o_32_s    <= 32'd0;
            o_ov_flag <= 1'b0;
            o_un_flag <= 1'b0;
            o_rsp_id  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        owner_reg <= grant_idx;
                        op_reg    <= i_add_sub[grant_idx];
                        a_reg     <= i_32_a[grant_idx];
                        b_reg     <= i_32_b[grant_idx];
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    o_32_s    <= fpu_s;
                    o_ov_flag <= fpu_ov;
                    o_un_flag <= fpu_un;
                    o_rsp_id  <= owner_reg;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready[o_rsp_id]) begin
                        rr_reg    <= ~o_rsp_id;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: reset, single/contended grants, backpressure, flags, mid-op reset.
module tb_fpu_arbiter;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [1:0]       i_req_valid;
    logic [1:0]       o_req_ready;
    logic [1:0]       i_add_sub;
    logic [1:0][31:0] i_32_a;
    logic [1:0][31:0] i_32_b;
    logic [1:0]       o_rsp_valid;
    logic [1:0]       i_rsp_ready;
    logic [31:0]      o_32_s;
    logic             o_ov_flag;
    logic             o_un_flag;
    logic             o_rsp_id;
    logic             o_busy;
    logic [31:0]      ref_s;
    logic             ref_ov;
    logic             ref_un;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    fpu_arbiter #(.NUM_OP(1)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_add_sub  (i_add_sub),
        .i_32_a     (i_32_a),
        .i_32_b     (i_32_b),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_32_s     (o_32_s),
        .o_ov_flag  (o_ov_flag),
        .o_un_flag  (o_un_flag),
        .o_rsp_id   (o_rsp_id),
        .o_busy     (o_busy)
    );

    // Standalone unit fed with requester 1's operands as an add
    FPU_unit #(.NUM_OP(1)) u_ref (
        .i_add_sub(1'b0),
        .i_32_a   (i_32_a[1]),
        .i_32_b   (i_32_b[1]),
        .o_32_s   (ref_s),
        .o_ov_flag(ref_ov),
        .o_un_flag(ref_un)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // One full transaction: grant, EXEC, optional stall with non-owner ready, then accept
    task automatic run_op(input logic [1:0] valid, input logic [1:0] valid_after, input logic gnt,
                          input int stall, input logic [31:0] exp_s, input logic [1:0] exp_flags,
                          input string name);
        logic [1:0] oh;
        oh = gnt ? 2'b10 : 2'b01;
        i_req_valid = valid;
        #1;
        check_val({name, "/grant"}, 32'(o_req_ready), 32'(oh));
        step();
        i_req_valid = valid_after;
        #1;
        check_val({name, "/exec_busy_rdy_vld"}, 32'({o_busy, o_req_ready, o_rsp_valid}), 32'(5'b10000));
        step();
        for (int k = 0; k < stall; k++) begin
            i_rsp_ready = ~oh;
            #1;
            check_val({name, "/stall_busy_rdy_vld"}, 32'({o_busy, o_req_ready, o_rsp_valid}),
                      32'({1'b1, 2'b00, oh}));
            check_val({name, "/stall_s"}, o_32_s, exp_s);
            step();
        end
        i_rsp_ready = oh;
        #1;
        check_val({name, "/rsp_valid"}, 32'(o_rsp_valid), 32'(oh));
        check_val({name, "/s"}, o_32_s, exp_s);
        check_val({name, "/flags"}, 32'({o_ov_flag, o_un_flag}), 32'(exp_flags));
        check_val({name, "/id"}, 32'(o_rsp_id), 32'(gnt));
        step();
        i_rsp_ready = 2'b00;
        #1;
        check_val({name, "/done_busy_vld"}, 32'({o_busy, o_rsp_valid}), 32'(3'b000));
    endtask

    initial begin
        i_rst       = 1'b1;
        i_req_valid = 2'b11;
        i_rsp_ready = 2'b00;
        i_add_sub   = 2'b10;
        i_32_a[0]   = 32'h4040_0000;
        i_32_b[0]   = 32'h3F80_0000;
        i_32_a[1]   = 32'h40A0_0000;
        i_32_b[1]   = 32'h3F80_0000;

        for (int c = 0; c < 3; c++) begin
            step();
            check_val("rst/busy_rdy_vld", 32'({o_busy, o_req_ready, o_rsp_valid}), 32'd0);
        end
        check_val("rst/s", o_32_s, 32'd0);
        check_val("rst/flags_id", 32'({o_ov_flag, o_un_flag, o_rsp_id}), 32'd0);
        i_rst = 1'b0;

        run_op(2'b11, 2'b00, 1'b0, 0, 32'h4080_0000, 2'b00, "rst_first_grant");
        run_op(2'b01, 2'b00, 1'b0, 0, 32'h4080_0000, 2'b00, "single_req0");
        run_op(2'b10, 2'b00, 1'b1, 0, 32'h4080_0000, 2'b00, "single_req1");
        run_op(2'b11, 2'b10, 1'b0, 5, 32'h4080_0000, 2'b00, "contend_req0_bp");
        run_op(2'b10, 2'b00, 1'b1, 0, 32'h4080_0000, 2'b00, "contend_req1");
        run_op(2'b11, 2'b00, 1'b0, 0, 32'h4080_0000, 2'b00, "contend_again");

        i_add_sub[1] = 1'b0;
        i_32_a[1]    = 32'h7F7F_FFFF;
        i_32_b[1]    = 32'h7F7F_FFFF;
        run_op(2'b10, 2'b00, 1'b1, 0, 32'h7F80_0000, 2'b10, "overflow");
        check_val("overflow/vs_unit_s", o_32_s, ref_s);
        check_val("overflow/vs_unit_flags", 32'({o_ov_flag, o_un_flag}), 32'({ref_ov, ref_un}));

        i_add_sub[0] = 1'b1;
        run_op(2'b01, 2'b00, 1'b0, 0, 32'h4000_0000, 2'b00, "sub_3_minus_1");
        i_32_a[0] = 32'h0080_0000;
        i_32_b[0] = 32'h0080_0001;
        run_op(2'b01, 2'b00, 1'b0, 0, 32'h8000_0000, 2'b01, "underflow");

        // Reset while the operation is in EXEC
        i_add_sub[0] = 1'b0;
        i_32_a[0]    = 32'h4040_0000;
        i_32_b[0]    = 32'h3F80_0000;
        i_req_valid  = 2'b01;
        step();
        i_req_valid  = 2'b00;
        i_rsp_ready  = 2'b11;
        #1;
        check_val("midrst/exec_busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        #1;
        check_val("midrst/held_busy_vld", 32'({o_busy, o_rsp_valid}), 32'd0);
        step();
        i_rst = 1'b0;
        #1;
        check_val("midrst/s_cleared", o_32_s, 32'd0);
        for (int c = 0; c < 4; c++) begin
            check_val("midrst/idle_busy_rdy_vld", 32'({o_busy, o_req_ready, o_rsp_valid}), 32'd0);
            step();
        end
        i_rsp_ready = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter NUM_OP, default 1, passed unchanged to the FPU_unit instance.
REQ-002 SHALL have parameter NUM_REQ, fixed at 2, giving the requester count.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_req_valid  input  2  per-requester operation request.
REQ-007 o_req_ready  output  2  per-requester operand-accept strobe.
REQ-008 i_add_sub  input  2  per-requester op select: 0 = add, 1 = subtract.
REQ-009 i_32_a  input  2x32  per-requester operand A, IEEE-754 single.
REQ-010 i_32_b  input  2x32  per-requester operand B, IEEE-754 single.
REQ-011 o_rsp_valid  output  2  per-requester result valid.
REQ-012 i_rsp_ready  input  2  per-requester result accept.
REQ-013 o_32_s  output  32  registered result, shared by both requesters.
REQ-014 o_ov_flag / o_un_flag  output  1 each  registered FPU overflow/underflow for o_32_s.
REQ-015 o_rsp_id  output  1  requester index owning the current result.
REQ-016 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL share one combinational FPU_unit between both requesters using a three-state FSM: IDLE, EXEC, RESP.
REQ-018 IDLE: if any i_req_valid, grant one requester and capture its op/A/B into operand registers; next state EXEC. Otherwise stay in IDLE.
REQ-019 o_req_ready[g] SHALL be high combinationally only in IDLE, and only for the granted index g; the other bit SHALL be 0.
REQ-020 Arbitration: if exactly one requester is valid, grant it. If both are valid, grant the requester selected by round-robin pointer rr.
REQ-021 EXEC: FPU_unit SHALL be driven from the operand registers only. At the end of the cycle, o_32_s, o_ov_flag, o_un_flag and o_rsp_id SHALL be latched; next state RESP.
REQ-022 RESP: o_rsp_valid[o_rsp_id]=1, other bit 0. When i_rsp_ready[o_rsp_id]=1: set rr = ~o_rsp_id and go to IDLE. Otherwise hold.
REQ-023 Latency: accept edge E0 -> o_rsp_valid asserted after E0+1 edge; minimum 3 cycles per operation; one operation in flight.
REQ-024 o_32_s, the flags and o_rsp_id SHALL stay stable while o_rsp_valid is high and stalled, and hold their last value in IDLE.
REQ-025 i_rsp_ready on the non-owning bit SHALL be ignored. i_req_valid changes during EXEC/RESP SHALL have no effect.
REQ-026 A requester dropping i_req_valid before its grant SHALL not be served. No request is queued.
REQ-027 Zero/inf/denormal handling, rounding and flag generation SHALL be exactly those of FPU_unit; the block performs no arithmetic itself.

Reset
REQ-028 On i_rst=1 at a clock edge: state=IDLE, rr=0, operand registers=0, o_32_s=0, flags=0, o_rsp_id=0.
REQ-029 While i_rst=1: o_rsp_valid=0, o_req_ready=0, o_busy=0.
REQ-030 Reset in EXEC or RESP SHALL abandon the operation; no response is issued after reset deasserts.

Structure
REQ-031 A shared package fpu_arb_pkg SHALL hold the state enum (IDLE/EXEC/RESP) and constant NUM_REQ=2.
REQ-032 SHALL instantiate exactly one sub-module, FPU_unit (parameter NUM_OP). The arbiter FSM and registers are in fpu_arbiter itself.

Verification
REQ-033 Reset check: assert i_rst for 3 cycles with both i_req_valid=1 -> all outputs 0; first grant goes to req0 after release.
REQ-034 Single requester: req0 add, 0x40400000 + 0x3F800000 -> o_req_ready[0] pulses one cycle; o_rsp_valid[0] one edge later with o_32_s=0x40800000, o_rsp_id=0, flags 0.
REQ-035 Contention: both valid, req0 = 0x40400000 + 0x3F800000 add, req1 = 0x40A00000 - 0x3F800000 subtract -> req0 served first, then req1; both results 0x40800000; next contention grants req0 again (rr alternates).
REQ-036 Backpressure: hold i_rsp_ready=0 for 5 cycles in RESP -> o_32_s stable, o_busy=1, o_req_ready=00; completes on the first cycle i_rsp_ready[id]=1.
REQ-037 Overflow: req1 add 0x7F7FFFFF + 0x7F7FFFFF -> o_ov_flag=1 with o_rsp_valid[1]; o_32_s equals the standalone FPU_unit output for the same inputs.
REQ-038 Mid-op reset: assert i_rst in EXEC -> next cycle IDLE, o_rsp_valid=00 throughout, no stale response after release.
